// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, drives the instruction
//               memory address, captures the combinational return word into
//               a DEPTH-entry queue and presents {pc, instr} pairs to decode
//               over valid/ready. Redirects flush the queue and reload the PC.
// Option      : FETCH_MISALIGN_TRAP_EN - misaligned redirect target sets a
//               sticky fetch_err and blocks all further fetching.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      q_pc_q    [DEPTH];
  logic [31:0]      q_pc_d    [DEPTH];
  logic [31:0]      q_instr_q [DEPTH];
  logic [31:0]      q_instr_d [DEPTH];

  logic pop;
  logic push;
  logic fetch_blocked;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign fetch_blocked = err_q;
  assign fetch_err     = err_q;
`else
  // Low target bits are simply dropped in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign fetch_blocked        = 1'b0;
`endif

  // Output view of the queue head; a redirect cycle never offers data.
  always_comb begin
    imem_addr = pc_q;
    out_valid = (count_q != '0) & ~redirect;
    out_pc    = q_pc_q[rd_ptr_q];
    out_instr = q_instr_q[rd_ptr_q];
  end

  // Handshake and capture decisions; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop  = out_valid & out_ready;
    push = ~redirect & ~fetch_blocked & ((count_q < DEPTH_CNT) | pop);
  end

  // Next-state: redirect flushes and reloads, otherwise push/pop the queue.
  always_comb begin
    pc_d      = pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    q_pc_d    = q_pc_q;
    q_instr_d = q_instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_d     = err_q;
`endif
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
`endif
    end else begin
      if (push) begin
        q_pc_d[wr_ptr_q]    = pc_q;
        q_instr_d[wr_ptr_q] = imem_data;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        pc_d                = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      q_pc_q    <= '{default: '0};
      q_instr_q <= '{default: '0};
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      q_pc_q    <= q_pc_d;
      q_instr_q <= q_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A queue-based model of the
//               fetch stage is compared with the DUT on every falling edge;
//               directed cycles also pin literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pending {pc, instr} pairs, the PC, and the sticky error.
  logic [63:0] mq[$];
  logic [31:0] m_pc  = RESET_PC;
  logic        m_err = 1'b0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_err  (fetch_err)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: words 0..6 hold 0x11..0x77, elsewhere an address tag.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    if (w < 32'd7) return (w + 32'd1) * 32'h11;
    return 32'hDEAD_0000 ^ a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge, from the rules for push, pop and redirect.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_pc  = RESET_PC;
        m_err = 1'b0;
      end else begin
        automatic bit pop_m  = (mq.size() != 0) && !redirect && out_ready;
        automatic bit push_m = !redirect && !m_err && ((mq.size() < DEPTH) || pop_m);
        if (redirect) begin
          mq.delete();
          m_pc = redirect_pc & ~32'h3;
          if (TRAP && redirect_pc[1:0] != 2'b00) m_err = 1'b1;
        end else begin
          if (pop_m) void'(mq.pop_front());
          if (push_m) begin
            mq.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    automatic bit exp_valid = (mq.size() != 0) && !redirect;
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("m_out_pc", out_pc, mq[0][63:32]);
      chk("m_out_instr", out_instr, mq[0][31:0]);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("m_fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
`endif
  end

  // Inputs for one cycle are applied just after the edge; checks follow later.
  task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #2;
  endtask

  task automatic head(input string name, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] addr);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_pc"}, out_pc, pc);
    chk({name, "_instr"}, out_instr, instr);
    chk({name, "_addr"}, imem_addr, addr);
  endtask

  task automatic empty(input string name, input logic [31:0] addr);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    logic [19:0] pattern;
    reset_n     = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #1 reset_n = 1'b0;
    #2;
    empty("reset_async", 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #2;
    empty("reset_release", 32'h0);

    // Streaming with ready held high: one pair per cycle.
    cyc(1'b1, 1'b0, 32'h0); head("stream0", 32'h0, 32'h11, 32'h4);
    cyc(1'b1, 1'b0, 32'h0); head("stream1", 32'h4, 32'h22, 32'h8);
    cyc(1'b1, 1'b0, 32'h0); head("stream2", 32'h8, 32'h33, 32'hC);

    // Restart at 0, then back-pressure fills the queue and holds the PC.
    cyc(1'b1, 1'b1, 32'h0); chk("redir_valid", {31'b0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0); empty("flush", 32'h0);
    cyc(1'b0, 1'b0, 32'h0); head("fill1", 32'h0, 32'h11, 32'h4);
    cyc(1'b0, 1'b0, 32'h0); head("full", 32'h0, 32'h11, 32'h8);
    repeat (3) begin
      cyc(1'b0, 1'b0, 32'h0); head("hold", 32'h0, 32'h11, 32'h8);
    end
    cyc(1'b1, 1'b0, 32'h0); head("drain0", 32'h0, 32'h11, 32'h8);
    cyc(1'b1, 1'b0, 32'h0); head("drain1", 32'h4, 32'h22, 32'hC);
    cyc(1'b1, 1'b0, 32'h0); head("drain2", 32'h8, 32'h33, 32'h10);

    // Redirect to 0x10 while full, with ready high during the redirect.
    cyc(1'b0, 1'b0, 32'h0);  head("prefull", 32'hC, 32'h44, 32'h14);
    cyc(1'b1, 1'b1, 32'h10); chk("redir10_valid", {31'b0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);  empty("redir10_n1", 32'h10);
    cyc(1'b1, 1'b0, 32'h0);  head("redir10_n2", 32'h10, 32'h55, 32'h14);
    cyc(1'b1, 1'b0, 32'h0);  head("redir10_n3", 32'h14, 32'h66, 32'h18);

    // Redirect to the last word of the address space: PC wraps to 0.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC); chk("redirtop_valid", {31'b0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0); empty("top_n1", 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0); head("top_n2", 32'hFFFF_FFFC, 32'h2152_FFFC, 32'h0);
    cyc(1'b1, 1'b0, 32'h0); head("wrap", 32'h0, 32'h11, 32'h4);

    // Misaligned redirect to 0x6.
    cyc(1'b1, 1'b1, 32'h6); chk("mis_valid", {31'b0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0); empty("mis_n1", 32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_err", {31'b0, fetch_err}, 32'd1);
    cyc(1'b1, 1'b0, 32'h0); empty("trap_hold", 32'h4);
    cyc(1'b1, 1'b1, 32'h10);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0); empty("trap_sticky", 32'h10);
    chk("trap_err_sticky", {31'b0, fetch_err}, 32'd1);
`else
    cyc(1'b1, 1'b0, 32'h0); head("mis_resume", 32'h4, 32'h22, 32'h8);
`endif

    // Reset in the middle of a cycle clears everything asynchronously.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    empty("midreset", RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("midreset_err", {31'b0, fetch_err}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #2;
    cyc(1'b1, 1'b0, 32'h0); head("rerun0", 32'h0, 32'h11, 32'h4);

    // Mixed back-pressure pattern, checked by the model every cycle.
    pattern = 20'b1011_0010_1110_0101_1001;
    for (int i = 0; i < 20; i++) begin
      cyc(pattern[i], 1'b0, 32'h0);
    end
    cyc(1'b1, 1'b1, 32'h8);
    for (int i = 0; i < 8; i++) begin
      cyc(pattern[i], 1'b0, 32'h0);
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `instruction_memory`. Holds the program counter and drives the memory address. Captures the combinationally returned instruction word into a small FIFO and presents `{pc, instr}` pairs to the decode stage over a valid/ready handshake. Supports branch/jump redirection with queue flush, and back-pressure from decode.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `DEPTH`, default `2`: fetch queue entries; power of two, ≥ 2.
- `clk` input 1: clock, rising-edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `imem_addr` output 32: byte address to `instruction_memory`; always equals the current PC register.
- `imem_data` input 32: instruction word returned combinationally for `imem_addr` in the same cycle.
- `redirect` input 1: redirect request from execute (branch taken / jump).
- `redirect_pc` input 32: redirect target byte address.
- `out_valid` output 1: queue head is valid and no redirect is active this cycle.
- `out_ready` input 1: decode accepts the head this cycle.
- `out_pc` output 32: PC of the head entry.
- `out_instr` output 32: instruction of the head entry.
- `fetch_err` output 1: sticky misaligned-redirect error. Present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- State consists of the PC register, a circular queue of `DEPTH` × {pc[31:0], instr[31:0]}, read/write pointers, and a count of width clog2(`DEPTH`)+1.
- pop = `out_valid & out_ready`.
- push = `!redirect & (count < DEPTH | pop)` (and `!fetch_err` when the trap is enabled).
- On push:
  - Write {PC, `imem_data`} at the write pointer.
  - PC ← PC + 4, modulo 2^32; `32'hFFFF_FFFC` wraps to `0`.
- On pop: advance the read pointer.
- Simultaneous push and pop keeps count unchanged. This is legal when the queue is full.
- Redirect has priority over push and pop:
  - Queue is flushed: pointers and count go to 0.
  - PC ← `redirect_pc` with bits [1:0] cleared.
  - No capture occurs that cycle.
- `out_valid = (count != 0) & !redirect`. Because of this, no handshake can complete in a redirect cycle.
- `out_pc` and `out_instr` read the head entry. They are don't-care when `out_valid` is 0.
- The fetch path has no FSM beyond this: it is either filling, holding while full, or flushing.

## Timing
- Reset (async assert): PC = `RESET_PC`, count = 0, pointers = 0, `out_valid` = 0, `imem_addr` = `RESET_PC`, `fetch_err` = 0.
- Deassertion is taken at the next rising edge. The first push occurs on the first rising edge after `reset_n` is high.
- Latency: an instruction at PC X is presented on `out_*` one cycle after `imem_addr` = X, assuming no redirect.
- Sustained throughput is 1 instruction/cycle when `out_ready` is held high.
- Redirect asserted in cycle N: `imem_addr` = target in cycle N+1, and the first target instruction is valid in N+2. Redirect penalty is 2 cycles.
- Back-pressure: with `out_ready` = 0, the queue fills after `DEPTH` cycles. PC then holds and `imem_addr` is stable.
- Reset asserted mid-operation immediately empties the queue and drops `out_valid` asynchronously.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_err` (sticky until reset).
  - The queue is flushed, PC is loaded with the aligned target, and all further pushes are blocked. `out_valid` stays 0.
  - A later redirect does not clear the error.
- Undefined:
  - `fetch_err` port is absent.
  - Low target bits are silently cleared and fetch continues.

## Test plan
- Reset release with `RESET_PC` = 0, memory words 0..6 = `32'h11`..`32'h77`, `out_ready` = 1 -> `out_valid` rises one cycle after the first edge; pairs (0,`11`),(4,`22`),(8,`33`)… arrive one per cycle.
- `out_ready` = 0 for 5 cycles -> count saturates at 2 and `imem_addr` holds at 8. On release, (0,`11`),(4,`22`),(8,`33`) follow with no gap and no duplicate.
- Redirect to `32'h10` while the queue is full -> `out_valid` = 0 that cycle and the next. The next accepted pair is (`10`, `55`); no stale entry appears.
- Redirect asserted while `out_ready` = 1 and the queue is non-empty -> no handshake that cycle; the head entry is discarded.
- PC = `32'hFFFF_FFFC` via redirect -> the next `imem_addr` is `0`.
- Redirect to `32'h6`:
  - With `FETCH_MISALIGN_TRAP_EN`: `fetch_err` = 1, `out_valid` stays 0 until reset.
  - Without it: fetch resumes at `32'h4`.
